// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU: controller states, opcode
// constants, instruction field positions and ALU select encodings.
package cpu_pkg;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_IMM,
        ST_HALT
    } state_t;

    // Non-ALU opcodes live in ir[6:5] when ir[7] is set
    localparam logic [1:0] OP_LDI  = 2'b00;
    localparam logic [1:0] OP_OUT  = 2'b01;
    localparam logic [1:0] OP_JC   = 2'b10;
    localparam logic [1:0] OP_HALT = 2'b11;

    localparam int IR_CLASS_BIT = 7;
    localparam int IR_OP_HI     = 6;
    localparam int IR_OP_LO     = 5;
    localparam int IR_SEL_HI    = 6;
    localparam int IR_SEL_LO    = 4;
    localparam int IR_RD_HI     = 3;
    localparam int IR_RD_LO     = 2;
    localparam int IR_RS_HI     = 1;
    localparam int IR_RS_LO     = 0;

    // Select encodings understood by alu_8bit
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_NOT = 3'b101;
    localparam logic [2:0] ALU_SHL = 3'b110;
    localparam logic [2:0] ALU_SHR = 3'b111;

    function automatic logic ir_is_alu(input logic [7:0] ir);
        return ~ir[IR_CLASS_BIT];
    endfunction

    function automatic logic [1:0] ir_op(input logic [7:0] ir);
        return ir[IR_OP_HI:IR_OP_LO];
    endfunction

    function automatic logic [1:0] ir_rd(input logic [7:0] ir);
        return ir[IR_RD_HI:IR_RD_LO];
    endfunction

    function automatic logic [1:0] ir_rs(input logic [7:0] ir);
        return ir[IR_RS_HI:IR_RS_LO];
    endfunction

    function automatic logic [2:0] ir_sel(input logic [7:0] ir);
        return ir[IR_SEL_HI:IR_SEL_LO];
    endfunction

endpackage

// File: rtl/cpu_regfile.sv
// 4x8 register file: two asynchronous read ports, one synchronous write
// port, all registers cleared by synchronous reset.
module cpu_regfile
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] rd_addr_a,
    output logic [7:0] rd_data_a,
    input  logic [1:0] rd_addr_b,
    output logic [7:0] rd_data_b,
    input  logic       wr_en,
    input  logic [1:0] wr_addr,
    input  logic [7:0] wr_data
);

    logic [7:0] regs [4];

    // Reset has priority so a write scheduled in a reset cycle is dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                regs[i] <= 8'h00;
            end
        end else if (wr_en) begin
            regs[wr_addr] <= wr_data;
        end
    end

    assign rd_data_a = regs[rd_addr_a];
    assign rd_data_b = regs[rd_addr_b];

endmodule

// File: rtl/cpu_control_unit.sv
// Multi-cycle fetch/decode/execute controller for the 8-bit CPU. Drives
// the external combinational ALU and writes its result back.
module cpu_control_unit
    import cpu_pkg::*;
#(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    output logic       imem_req,
    output logic [7:0] imem_addr,
    input  logic       imem_ack,
    input  logic [7:0] imem_data,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [2:0] alu_sel,
    input  logic [7:0] alu_out,
    input  logic       alu_carry,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic       halted
);

    state_t     state;
    logic [7:0] pc;
    logic [7:0] ir;
    logic       carry;

    logic [7:0] reg_rd_val;
    logic [7:0] reg_rs_val;
    logic       reg_wr_en;
    logic [7:0] reg_wr_data;

    cpu_regfile u_regfile (
        .clk       (clk),
        .rst       (rst),
        .rd_addr_a (ir_rd(ir)),
        .rd_data_a (reg_rd_val),
        .rd_addr_b (ir_rs(ir)),
        .rd_data_b (reg_rs_val),
        .wr_en     (reg_wr_en),
        .wr_addr   (ir_rd(ir)),
        .wr_data   (reg_wr_data)
    );

    // Fetch port is a pure decode of the registered state, masked in reset
    assign imem_req  = ~rst & ((state == ST_FETCH) | (state == ST_IMM));
    assign imem_addr = pc;

    // Operands always follow the current ir; only the EXEC value is used
    assign alu_a   = reg_rd_val;
    assign alu_b   = reg_rs_val;
    assign alu_sel = ir_sel(ir);

    // Writeback source: ALU result in EXEC, fetched immediate in IMM
    always_comb begin
        reg_wr_en   = 1'b0;
        reg_wr_data = alu_out;
        if (state == ST_EXEC) begin
            reg_wr_en = 1'b1;
        end else if ((state == ST_IMM) && imem_ack) begin
            reg_wr_en   = 1'b1;
            reg_wr_data = imem_data;
        end
    end

    // Controller FSM with pc, ir, carry flag and output port registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_FETCH;
            pc        <= RESET_PC;
            ir        <= 8'h00;
            carry     <= 1'b0;
            out_data  <= 8'h00;
            out_valid <= 1'b0;
            halted    <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                ST_FETCH: begin
                    if (imem_ack) begin
                        ir    <= imem_data;
                        pc    <= pc + 8'd1;
                        state <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (ir_is_alu(ir)) begin
                        state <= ST_EXEC;
                    end else begin
                        case (ir_op(ir))
                            OP_LDI: begin
                                state <= ST_IMM;
                            end
                            OP_OUT: begin
                                out_data  <= reg_rd_val;
                                out_valid <= 1'b1;
                                state     <= ST_FETCH;
                            end
                            OP_JC: begin
                                if (carry) begin
                                    pc <= reg_rd_val;
                                end
                                state <= ST_FETCH;
                            end
                            default: begin
                                halted <= 1'b1;
                                state  <= ST_HALT;
                            end
                        endcase
                    end
                end
                ST_EXEC: begin
                    carry <= alu_carry;
                    state <= ST_FETCH;
                end
                ST_IMM: begin
                    if (imem_ack) begin
                        pc    <= pc + 8'd1;
                        state <= ST_FETCH;
                    end
                end
                ST_HALT: begin
                    state <= ST_HALT;
                end
                default: begin
                    state <= ST_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_control_unit.sv
// Scoreboard bench for cpu_control_unit: an instruction-level model of the
// program predicts fetch addresses, fetch spacing and output bytes; a
// monitor compares them as the DUT presents fetches and output strobes.
module tb_cpu_control_unit;

    localparam logic [7:0] RESET_PC = 8'hFE;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_ack = 1'b0;
    logic [7:0] imem_data = 8'h00;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [2:0] alu_sel;
    logic [7:0] alu_out;
    logic       alu_carry;
    logic [7:0] out_data;
    logic       out_valid;
    logic       halted;

    cpu_control_unit #(.RESET_PC(RESET_PC)) dut (
        .clk       (clk),
        .rst       (rst),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .imem_data (imem_data),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_sel   (alu_sel),
        .alu_out   (alu_out),
        .alu_carry (alu_carry),
        .out_data  (out_data),
        .out_valid (out_valid),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] addr;
        int         gap;
    } fetch_exp_t;

    fetch_exp_t fetch_q[$];
    logic [7:0] out_q[$];
    logic [7:0] mem [256];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_acc = -1;
    int wait_mode = 0;
    int wait_cnt = 0;
    int wait_tgt = 0;

    // Behaviour of the external alu_8bit: {carry, result}
    function automatic logic [8:0] alu_fn(input logic [2:0] sel, input logic [7:0] a, input logic [7:0] b);
        case (sel)
            3'd0:    return {1'b0, a} + {1'b0, b};
            3'd1:    return {1'b0, a} - {1'b0, b};
            3'd2:    return {1'b0, a & b};
            3'd3:    return {1'b0, a | b};
            3'd4:    return {1'b0, a ^ b};
            3'd5:    return {1'b0, ~a};
            3'd6:    return {a, 1'b0};
            default: return {a[0], 1'b0, a[7:1]};
        endcase
    endfunction

    always_comb begin
        {alu_carry, alu_out} = alu_fn(alu_sel, alu_a, alu_b);
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    function automatic int pickWait();
        return (wait_mode < 0) ? int'($urandom_range(0, 3)) : wait_mode;
    endfunction

    // Memory responder: acknowledges each request after a chosen number of wait cycles
    always @(negedge clk) begin
        if (rst || !imem_req) begin
            imem_ack = 1'b0;
            wait_cnt = 0;
            wait_tgt = pickWait();
        end else if (wait_cnt >= wait_tgt) begin
            imem_ack  = 1'b1;
            imem_data = mem[imem_addr];
            wait_cnt  = 0;
            wait_tgt  = pickWait();
        end else begin
            imem_ack = 1'b0;
            wait_cnt++;
        end
    end

    // Monitor: pops the scoreboard on every accepted fetch and output strobe
    always @(negedge clk) begin
        fetch_exp_t fe;
        #1;
        if (rst) begin
            last_acc = -1;
        end else begin
            if (imem_req && imem_ack) begin
                if (fetch_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL fetch_extra: got addr %0h, expected no fetch", imem_addr);
                end else begin
                    fe = fetch_q.pop_front();
                    checkOutput("fetch_addr", int'(imem_addr), int'(fe.addr));
                    if (fe.gap >= 0 && last_acc >= 0)
                        checkOutput("fetch_gap", cyc + 1 - last_acc, fe.gap);
                end
                last_acc = cyc + 1;
            end
            if (out_valid) begin
                if (out_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL out_extra: got out_data %0h, expected no strobe", out_data);
                end else begin
                    checkOutput("out_data", int'(out_data), int'(out_q.pop_front()));
                end
            end
        end
    end

    // Instruction-level reference: runs the program in mem from RESET_PC
    task automatic buildExpect(input int w, input bit commit, output bit halts);
        logic [7:0] pc;
        logic [7:0] ir;
        logic [7:0] r [4];
        logic [8:0] res;
        bit         c;
        int         gap;
        fetch_exp_t fq[$];
        logic [7:0] oq[$];
        pc = RESET_PC;
        c = 1'b0;
        r = '{default: 8'h00};
        gap = -1;
        halts = 1'b0;
        for (int n = 0; n < 100 && !halts; n++) begin
            fq.push_back('{addr: pc, gap: gap});
            ir = mem[pc];
            pc = pc + 8'd1;
            if (!ir[7]) begin
                res = alu_fn(ir[6:4], r[ir[3:2]], r[ir[1:0]]);
                r[ir[3:2]] = res[7:0];
                c = res[8];
                gap = (w < 0) ? -1 : w + 3;
            end else begin
                case (ir[6:5])
                    2'b00: begin
                        fq.push_back('{addr: pc, gap: (w < 0) ? -1 : w + 2});
                        r[ir[3:2]] = mem[pc];
                        pc = pc + 8'd1;
                        gap = (w < 0) ? -1 : w + 1;
                    end
                    2'b01: begin
                        oq.push_back(r[ir[3:2]]);
                        gap = (w < 0) ? -1 : w + 2;
                    end
                    2'b10: begin
                        if (c) pc = r[ir[3:2]];
                        gap = (w < 0) ? -1 : w + 2;
                    end
                    default: halts = 1'b1;
                endcase
            end
        end
        if (halts && commit) begin
            foreach (fq[i]) fetch_q.push_back(fq[i]);
            foreach (oq[i]) out_q.push_back(oq[i]);
        end
    endtask

    task automatic loadProg(input logic [7:0] prog[$]);
        for (int i = 0; i < 256; i++) mem[i] = 8'hE0;
        foreach (prog[i]) mem[RESET_PC + 8'(i)] = prog[i];
    endtask

    // Reset the DUT, arm the scoreboard for the loaded program, release reset
    task automatic applyStimulus(input int w);
        bit halts;
        @(posedge clk);
        #2 rst = 1'b1;
        wait_mode = w;
        repeat (2) @(posedge clk);
        fetch_q.delete();
        out_q.delete();
        buildExpect(w, 1'b1, halts);
        #2 rst = 1'b0;
        @(negedge clk);
        #2;
        checkOutput("first_req", int'(imem_req), 1);
        checkOutput("first_addr", int'(imem_addr), int'(RESET_PC));
        checkOutput("halted_after_rst", int'(halted), 0);
    endtask

    task automatic finishProgram();
        int n;
        n = 0;
        while (!halted && n < 2000) begin
            @(negedge clk);
            #2;
            n++;
        end
        checkOutput("halted", int'(halted), 1);
        checkOutput("fetch_left", fetch_q.size(), 0);
        checkOutput("out_left", out_q.size(), 0);
    endtask

    initial begin
        logic [7:0] p[$];
        logic [7:0] b;
        bit         ok;
        int         n;

        for (int i = 0; i < 256; i++) mem[i] = 8'hE0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2;
        checkOutput("rst_req", int'(imem_req), 0);
        checkOutput("rst_out_valid", int'(out_valid), 0);
        checkOutput("rst_out_data", int'(out_data), 0);
        checkOutput("rst_halted", int'(halted), 0);

        // LDI R0,6F; LDI R1,6F; ADD R0,R1; OUT R0; HALT (LDI immediate at FF)
        p = '{8'h80, 8'h6F, 8'h84, 8'h6F, 8'h01, 8'hA0, 8'hE0};
        loadProg(p);
        applyStimulus(0);
        finishProgram();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #2;
            checkOutput("halt_req", int'(imem_req), 0);
            checkOutput("halt_hold", int'(halted), 1);
        end

        $display("[TB] same program with three wait cycles per fetch");
        applyStimulus(3);
        finishProgram();

        // OUT R0 at FE, LDI R1 at FF with immediate wrapping to 00
        p = '{8'hA0, 8'h84, 8'h5A, 8'hA4, 8'hE0};
        loadProg(p);
        applyStimulus(0);
        finishProgram();

        // Carry set by FF+01, JC R2 taken to 40
        p = '{8'h80, 8'hFF, 8'h84, 8'h01, 8'h01, 8'h88, 8'h40, 8'hC8, 8'hA0, 8'hE0};
        loadProg(p);
        mem[8'h40] = 8'hA8;
        applyStimulus(0);
        finishProgram();

        // Carry clear from 01+01, JC R2 falls through
        p = '{8'h80, 8'h01, 8'h84, 8'h01, 8'h01, 8'h88, 8'h40, 8'hC8, 8'hA0, 8'hE0};
        loadProg(p);
        mem[8'h40] = 8'hA8;
        applyStimulus(1);
        finishProgram();

        $display("[TB] reset during EXEC of ADD R3,R1");
        p = '{8'h8C, 8'hF0, 8'h84, 8'h20, 8'h0D, 8'hAC, 8'hE0};
        loadProg(p);
        applyStimulus(0);
        n = 0;
        while (!(imem_req && imem_ack && imem_addr == 8'h02) && n < 100) begin
            @(negedge clk);
            #2;
            n++;
        end
        checkOutput("exec_reached", int'(n < 100), 1);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        #2;
        checkOutput("exec_rst_out_valid", int'(out_valid), 0);
        checkOutput("exec_rst_req", int'(imem_req), 0);
        // OUT R3 then JC R3: R3 and carry must both be clear
        p = '{8'hAC, 8'hCC, 8'hE0};
        loadProg(p);
        applyStimulus(0);
        finishProgram();

        $display("[TB] random programs");
        for (int t = 0; t < 16; t++) begin
            ok = 1'b0;
            for (int a = 0; a < 20 && !ok; a++) begin
                for (int i = 0; i < 256; i++) mem[i] = 8'hE0;
                n = $urandom_range(6, 24);
                for (int i = 0; i < n; i++) begin
                    b = 8'($urandom);
                    if (b[7:5] == 3'b111) b[7] = 1'b0;
                    mem[RESET_PC + 8'(i)] = b;
                end
                buildExpect(0, 1'b0, ok);
            end
            if (!ok) begin
                for (int i = 0; i < 256; i++) mem[i] = 8'hE0;
            end
            applyStimulus((t % 4 == 0) ? 0 : -1);
            finishProgram();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
